fifo_write_control: RTL
=======================

FIFO_WRITE_CONTROL -- requirements
Module: fifo_write_control

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two and at least 4; AW = $clog2(DEPTH).
REQ-002 Parameter ALMOST_FULL_LEVEL, default DEPTH-2, fill level at which almost_full asserts; SHALL lie in 1..DEPTH-1.
REQ-003 write_clock  in  1  write-domain clock.
REQ-004 write_reset_n  in  1  asynchronous active-low reset.
REQ-005 write_valid  in  1  producer offers one word this cycle.
REQ-006 write_ready  out  1  controller can accept a word.
REQ-007 mem_write_enable  out  1  storage-array write strobe.
REQ-008 mem_write_address  out  AW  storage-array write index.
REQ-009 write_pointer  out  AW+1  Gray-coded write pointer, sent to the read domain.
REQ-010 sync_read_pointer  in  AW+1  Gray-coded read pointer, already two-flop synchronized into write_clock.
REQ-011 full  out  1  FIFO holds DEPTH words.
REQ-012 almost_full  out  1  fill level >= ALMOST_FULL_LEVEL (macro-dependent).
REQ-013 fill_level  out  AW+1  conservative word count, 0..DEPTH.
REQ-014 overflow  out  1  sticky: a write was attempted while full.
REQ-015 overflow_clear  in  1  clears overflow.

Function
REQ-016 Internal binary pointer wbin (AW+1 bits) SHALL increment by 1 on accept = write_valid & write_ready and wrap modulo 2^(AW+1).
REQ-017 write_ready SHALL equal ~full, combinationally.
REQ-018 mem_write_enable SHALL equal accept; mem_write_address SHALL equal wbin[AW-1:0] of the current cycle (zero added latency).
REQ-019 write_pointer SHALL be registered, equal to bin2gray(wbin), and update the cycle after each accept.
REQ-020 full SHALL be registered, computed from next Gray pointer gnext: full <= (gnext == {~rgray[AW:AW-1], rgray[AW-2:0]}), where rgray = sync_read_pointer.
REQ-021 full SHALL assert on the edge that accepts the DEPTH-th outstanding word; no write SHALL be accepted while full.
REQ-022 full SHALL deassert no earlier than the edge after sync_read_pointer shows the freed entry; the two-cycle synchronizer delay is pessimistic, never unsafe.
REQ-023 fill_level SHALL be registered as (wbin_next - gray2bin(rgray)) mod 2^(AW+1).
REQ-024 A cycle with write_valid=1 and full=1 SHALL set overflow on the next edge, leave wbin unchanged and drive mem_write_enable=0.
REQ-025 overflow_clear SHALL clear overflow on the next edge; when set and clear occur together, set SHALL win.
REQ-026 Pointer wrap (wbin 2^(AW+1)-1 -> 0) SHALL leave full, fill_level and write_pointer consistent, with no glitch state.

Reset
REQ-027 While write_reset_n=0: wbin=0, write_pointer=0, full=0, almost_full=0, fill_level=0, overflow=0.
REQ-028 Reset SHALL abandon any in-flight write; write_ready SHALL be 1 on the first edge after release.

Configuration
REQ-029 Macro FIFO_ALMOST_FULL_EN defined: almost_full SHALL be registered as fill_level_next >= ALMOST_FULL_LEVEL.
REQ-030 Macro FIFO_ALMOST_FULL_EN undefined: almost_full SHALL be tied to 0, the comparator SHALL be absent, and ALMOST_FULL_LEVEL SHALL be ignored.

Structure
REQ-031 Package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the AW-derivation constant, shared with the read-side controller.
REQ-032 The pointer register and its Gray conversion SHALL form one sub-module, fifo_gray_counter, reused by the read side.

Verification (DEPTH=16, ALMOST_FULL_LEVEL=14, macro defined)
REQ-033 Reset release, rgray=0, no writes -> write_ready=1, full=0, fill_level=0, write_pointer=5'b00000.
REQ-034 16 back-to-back writes, rgray held at 0 -> mem_write_address 0..15; almost_full asserts after write 14; full asserts after write 16; fill_level=16.
REQ-035 Full, write_valid held 1 -> no mem_write_enable, overflow=1 next cycle; overflow_clear pulse -> overflow=0; simultaneous clear and new overflow -> overflow stays 1.
REQ-036 Full, rgray steps to bin2gray(1) -> full=0 and fill_level=15 one edge later; next write targets address 0.
REQ-037 Stream 40 words with reader in lockstep -> pointer wraps past 31; Gray write_pointer changes exactly one bit per accept.
REQ-038 Reset asserted mid-stream with fill_level=9 -> all outputs return to REQ-027 values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO write and read controllers:
// pointer-width derivation and binary/Gray conversions.
package fifo_pkg;

    // Widest pointer the conversion helpers handle.
    localparam int PTR_MAX_W = 32;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_counter.sv
// Binary pointer register with a registered Gray copy, shared by the
// write-side and read-side FIFO controllers.
module fifo_gray_counter
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray,
    output logic [W-1:0] gray_next
);

    always_comb begin
        bin_next  = bin + W'(inc);
        gray_next = W'(bin2gray(PTR_MAX_W'(bin_next)));
    end

    // Gray copy is registered so the crossing pointer never shows decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_write_control.sv
// Write-domain controller of an asynchronous FIFO: pointer, full/fill tracking
// and sticky overflow. Optional almost_full comparator: define FIFO_ALMOST_FULL_EN.
module fifo_write_control
    import fifo_pkg::*;
#(
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2,
    localparam int AW               = addr_width(DEPTH),
    localparam int PW               = AW + 1
) (
    input  logic          write_clock,
    input  logic          write_reset_n,
    input  logic          write_valid,
    output logic          write_ready,
    output logic          mem_write_enable,
    output logic [AW-1:0] mem_write_address,
    output logic [PW-1:0] write_pointer,
    input  logic [PW-1:0] sync_read_pointer,
    output logic          full,
    output logic          almost_full,
    output logic [PW-1:0] fill_level,
    output logic          overflow,
    input  logic          overflow_clear
);

    logic          accept;
    logic          overflow_set;
    logic          full_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] fill_next;
    logic [PW-1:0] full_match;

    assign write_ready       = ~full;
    assign accept            = write_valid & write_ready;
    assign overflow_set      = write_valid & full;
    assign mem_write_enable  = accept;
    assign mem_write_address = wbin[AW-1:0];

    fifo_gray_counter #(
        .W (PW)
    ) u_wptr (
        .clk       (write_clock),
        .rst_n     (write_reset_n),
        .inc       (accept),
        .bin       (wbin),
        .bin_next  (wbin_next),
        .gray      (write_pointer),
        .gray_next (wgray_next)
    );

    // Full when the next write pointer laps the read pointer by exactly DEPTH:
    // in Gray code that is the read pointer with its top two bits inverted.
    always_comb begin
        full_match = {~sync_read_pointer[AW:AW-1], sync_read_pointer[AW-2:0]};
        full_next  = (wgray_next == full_match);
        rbin       = PW'(gray2bin(PTR_MAX_W'(sync_read_pointer)));
        fill_next  = wbin_next - rbin;
    end

    always_ff @(posedge write_clock or negedge write_reset_n) begin
        if (!write_reset_n) begin
            full       <= 1'b0;
            fill_level <= '0;
        end else begin
            full       <= full_next;
            fill_level <= fill_next;
        end
    end

    // A new overflow event takes priority over a clear in the same cycle.
    always_ff @(posedge write_clock or negedge write_reset_n) begin
        if (!write_reset_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    always_ff @(posedge write_clock or negedge write_reset_n) begin
        if (!write_reset_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (fill_next >= PW'(ALMOST_FULL_LEVEL));
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule
